// File: rtl/alpu_cache_arbiter.sv
// Shares one alpu operand cache port between NUM_REQ requesters, retrying unacknowledged writes.
// Build option: define ALPU_ARB_FIXED_PRIORITY_EN for lowest-index-wins arbitration instead of round-robin.
module alpu_cache_arbiter #(
    parameter int unsigned NUM_REQ    = 4,
    parameter int unsigned DATA_WIDTH = 16,
    parameter int unsigned ADDR_WIDTH = 8,
    parameter int unsigned MAX_RETRY  = 3
) (
    input  logic                            clk,
    input  logic                            reset_n,
    input  logic [NUM_REQ-1:0]              req_valid_i,
    input  logic [NUM_REQ-1:0]              req_we_i,
    input  logic [NUM_REQ*ADDR_WIDTH-1:0]   req_addr_i,
    input  logic [NUM_REQ*DATA_WIDTH-1:0]   req_wdata_i,
    output logic [NUM_REQ-1:0]              req_ready_o,
    output logic [NUM_REQ-1:0]              rsp_valid_o,
    output logic [DATA_WIDTH-1:0]           rsp_rdata_o,
    output logic                            rsp_ok_o,
    output logic                            cache_ce_o,
    output logic                            cache_we_o,
    output logic [ADDR_WIDTH-1:0]           cache_addr_o,
    output logic [DATA_WIDTH-1:0]           cache_wdata_o,
    input  logic [DATA_WIDTH-1:0]           cache_rdata_i,
    input  logic                            cache_rvalid_i,
    input  logic                            cache_wack_i
);
    localparam int unsigned IDW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int unsigned RW  = 4;

    typedef enum logic [1:0] { IDLE, ISSUE, CHECK } state_e;

    state_e                 state_q, state_d;
    logic [IDW-1:0]         owner_q, owner_d;
    logic                   we_q, we_d;
    logic [ADDR_WIDTH-1:0]  addr_q, addr_d;
    logic [DATA_WIDTH-1:0]  wdata_q, wdata_d;
    logic [RW-1:0]          retry_q, retry_d;

    logic                   gnt_found;
    logic [IDW-1:0]         gnt_idx;
    logic                   accept;
    logic                   sel_we;
    logic [ADDR_WIDTH-1:0]  sel_addr;
    logic [DATA_WIDTH-1:0]  sel_wdata;

`ifdef ALPU_ARB_FIXED_PRIORITY_EN
    // Descending scan: the last hit, i.e. the lowest valid index, wins.
    always_comb begin
        gnt_found = 1'b0;
        gnt_idx   = '0;
        for (int i = int'(NUM_REQ) - 1; i >= 0; i--) begin
            if (req_valid_i[i]) begin
                gnt_found = 1'b1;
                gnt_idx   = IDW'(i);
            end
        end
    end
`else
    logic [IDW-1:0] last_q;
    logic [IDW-1:0] cand;

    // Scan from farthest to nearest after last_q so the first valid index above last_q wins.
    always_comb begin
        gnt_found = 1'b0;
        gnt_idx   = '0;
        cand      = '0;
        for (int k = int'(NUM_REQ); k >= 1; k--) begin
            cand = IDW'((int'(last_q) + k) % int'(NUM_REQ));
            if (req_valid_i[cand]) begin
                gnt_found = 1'b1;
                gnt_idx   = cand;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            last_q <= IDW'(NUM_REQ - 1);
        end else if (accept) begin
            last_q <= gnt_idx;
        end
    end
`endif

    // Gating with reset_n keeps the accept pulse low while reset is held.
    assign accept = (state_q == IDLE) && gnt_found && reset_n;

    always_comb begin
        sel_we    = 1'b0;
        sel_addr  = '0;
        sel_wdata = '0;
        for (int i = 0; i < int'(NUM_REQ); i++) begin
            if (gnt_idx == IDW'(i)) begin
                sel_we    = req_we_i[i];
                sel_addr  = req_addr_i[i*ADDR_WIDTH +: ADDR_WIDTH];
                sel_wdata = req_wdata_i[i*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            owner_q <= '0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            retry_q <= '0;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            retry_q <= retry_d;
        end
    end

    // Next state and response; cache flags are sampled in CHECK, one cycle after the ce pulse.
    always_comb begin
        state_d     = state_q;
        owner_d     = owner_q;
        we_d        = we_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        retry_d     = retry_q;
        req_ready_o = '0;
        rsp_valid_o = '0;
        rsp_rdata_o = '0;
        rsp_ok_o    = 1'b0;
        cache_ce_o  = 1'b0;
        cache_we_o  = 1'b0;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    req_ready_o[gnt_idx] = 1'b1;
                    owner_d = gnt_idx;
                    we_d    = sel_we;
                    addr_d  = sel_addr;
                    wdata_d = sel_wdata;
                    retry_d = '0;
                    state_d = ISSUE;
                end
            end
            ISSUE: begin
                cache_ce_o = 1'b1;
                cache_we_o = we_q;
                state_d    = CHECK;
            end
            CHECK: begin
                state_d = IDLE;
                if (!we_q) begin
                    rsp_valid_o[owner_q] = 1'b1;
                    rsp_rdata_o          = cache_rdata_i;
                    rsp_ok_o             = cache_rvalid_i;
                end else if (cache_wack_i) begin
                    rsp_valid_o[owner_q] = 1'b1;
                    rsp_ok_o             = 1'b1;
                end else if (retry_q < RW'(MAX_RETRY)) begin
                    retry_d = RW'(retry_q + RW'(1));
                    state_d = ISSUE;
                end else begin
                    rsp_valid_o[owner_q] = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign cache_addr_o  = addr_q;
    assign cache_wdata_o = wdata_q;

endmodule
